// File: rtl/axi4_read_address_queue.sv
`default_nettype none
// ============================================================================
// Module  : axi4_read_address_queue
// Brief   : AXI4-Lite AR master channel with request FIFO, outstanding-read
//           credit limit and optional ARREADY watchdog (AXI_AR_TIMEOUT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module axi4_read_address_queue #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic                                 STARTRA,
    input  logic [ADDR_WIDTH-1:0]                ra_addr,
    input  logic [2:0]                           ra_prot,
    output logic                                 ra_ready,
    input  logic                                 r_done,
    output logic [ADDR_WIDTH-1:0]                ARADDR,
    output logic [2:0]                           ARPROT,
    output logic                                 ARVALID,
    input  logic                                 ARREADY,
    output logic                                 ar_IDLE,
    output logic                                 ar_DONE,
    output logic [$clog2(DEPTH+1)-1:0]           ar_COUNT,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] ar_OUTSTANDING,
    output logic                                 ar_TIMEOUT
);

    localparam int C_PW = $clog2(DEPTH);
    localparam int C_CW = $clog2(DEPTH+1);
    localparam int C_OW = $clog2(MAX_OUTSTANDING+1);
    localparam int C_EW = ADDR_WIDTH + 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_EW-1:0]     r_mem [DEPTH];
    logic [C_PW-1:0]     r_wr_ptr;
    logic [C_PW-1:0]     r_rd_ptr;
    logic [C_CW-1:0]     r_count;
    logic [C_OW-1:0]     r_out;
    logic                r_done_q;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [2:0]          r_arprot;

    logic                w_push;
    logic                w_load;
    logic                w_hs;
    logic [C_OW:0]       w_out_plus;
    logic                w_out_dec;
    logic [C_OW:0]       w_out_nxt;

    assign ARVALID  = (r_state == ST_SEND);
    assign ARADDR   = r_araddr;
    assign ARPROT   = r_arprot;
    assign ar_COUNT = r_count;
    assign ar_OUTSTANDING = r_out;
    assign ar_DONE  = r_done_q;
    assign ra_ready = (r_count != C_CW'(DEPTH));
    assign ar_IDLE  = (r_count == '0) && !ARVALID && (r_out == '0);

    assign w_hs   = ARVALID & ARREADY;
    assign w_push = STARTRA & ra_ready;

    // A completion can only retire a read that exists, counting one
    // handshaking in this very cycle.
    assign w_out_plus = {1'b0, r_out} + {{C_OW{1'b0}}, w_hs};
    assign w_out_dec  = r_done && (w_out_plus != '0);
    assign w_out_nxt  = w_out_plus - {{C_OW{1'b0}}, w_out_dec};

    assign w_load = (!ARVALID || w_hs) && (r_count != '0)
                    && (w_out_nxt < (C_OW+1)'(MAX_OUTSTANDING));

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = ST_SEND;
        end else if (w_hs) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= ST_IDLE;
            r_araddr <= '0;
            r_arprot <= '0;
            r_done_q <= 1'b0;
            r_out    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= w_hs;
            r_out    <= w_out_nxt[C_OW-1:0];
            if (w_load) begin
                {r_araddr, r_arprot} <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_load) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_load) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ra_addr, ra_prot};
        end
    end

`ifdef AXI_AR_TIMEOUT_EN
    localparam int C_TW = $clog2(TIMEOUT_CYCLES+1);

    logic [C_TW-1:0] r_stall;
    logic            r_timeout;

    assign ar_TIMEOUT = r_timeout;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else if (!ARVALID || ARREADY) begin
            r_stall <= '0;
        end else begin
            if (r_stall != C_TW'(TIMEOUT_CYCLES)) begin
                r_stall <= r_stall + 1'b1;
            end
            if (r_stall >= C_TW'(TIMEOUT_CYCLES-1)) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign ar_TIMEOUT       = 1'b0;
`endif

endmodule
`default_nettype wire
